// File: rtl/fmab_pkg.sv
// Shared types and constants for the fmab sequencer slice.
package fmab_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam logic [31:0] CMD_NOP = 32'd0;
    localparam logic [31:0] CMD_MAC = 32'd1;
    localparam logic [31:0] CMD_CLR = 32'd2;

    localparam int OPQ_W = 128;

    // Lane 0 is the most significant word (x), lane 3 the least (w).
    function automatic logic [31:0] opq_lane(input logic [OPQ_W-1:0] q, input logic [1:0] idx);
        logic [31:0] lane_s;
        case (idx)
            2'd0:    lane_s = q[127:96];
            2'd1:    lane_s = q[95:64];
            2'd2:    lane_s = q[63:32];
            2'd3:    lane_s = q[31:0];
            default: lane_s = q[31:0];
        endcase
        return lane_s;
    endfunction

endpackage

// File: rtl/fmab_seq_if.sv
// Command, operand and result handshakes between the front-end and the sequencer.
interface fmab_seq_if
    import fmab_pkg::*;
#(
    parameter int LEN_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [LEN_W-1:0]   cmd_len;
    logic               cmd_clear;
    logic               op_valid;
    logic               op_ready;
    logic [OPQ_W-1:0]   op_data;
    logic               res_valid;
    logic               res_ready;
    logic [127:0]       res_acc;
    logic [39:0]        res_exp;

    modport master (
        output cmd_valid, cmd_len, cmd_clear, op_valid, op_data, res_ready,
        input  cmd_ready, op_ready, res_valid, res_acc, res_exp
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_clear, op_valid, op_data, res_ready,
        output cmd_ready, op_ready, res_valid, res_acc, res_exp
    );
endinterface

// File: rtl/fmab_seq_issue.sv
// Operand register stage: turns accepted clear commands and operand handshakes
// into one-cycle fmab requests; operands hold between requests.
module fmab_seq_issue
    import fmab_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  seq_state_t        state,
    input  logic              cmd_fire,
    input  logic              cmd_clear,
    input  logic              op_fire,
    input  logic [OPQ_W-1:0]  op_data,
    output logic              fma_req,
    output logic [31:0]       fma_command,
    output logic [31:0]       fma_x,
    output logic [31:0]       fma_y,
    output logic [31:0]       fma_z,
    output logic [31:0]       fma_w
);

    logic               req_r;
    logic [31:0]        cmd_r;
    logic [OPQ_W-1:0]   opnd_r;
    logic               req_nxt_s;
    logic [31:0]        cmd_nxt_s;
    logic [OPQ_W-1:0]   opnd_nxt_s;
    logic               issue_clr_s;
    logic               issue_mac_s;

    assign issue_clr_s = (state == IDLE) && cmd_fire && cmd_clear;
    assign issue_mac_s = (state == RUN) && op_fire;

    // Select what the datapath sees in the next cycle
    always_comb begin
        req_nxt_s  = 1'b0;
        cmd_nxt_s  = CMD_NOP;
        opnd_nxt_s = opnd_r;
        if (issue_clr_s) begin
            req_nxt_s  = 1'b1;
            cmd_nxt_s  = CMD_CLR;
            opnd_nxt_s = {OPQ_W{1'b0}};
        end else if (issue_mac_s) begin
            req_nxt_s  = 1'b1;
            cmd_nxt_s  = CMD_MAC;
            opnd_nxt_s = op_data;
        end else begin
            req_nxt_s  = 1'b0;
            cmd_nxt_s  = CMD_NOP;
        end
    end

    // Request/operand register feeding fmab
    always_ff @(posedge clk) begin
        if (reset) begin
            req_r  <= 1'b0;
            cmd_r  <= CMD_NOP;
            opnd_r <= {OPQ_W{1'b0}};
        end else begin
            req_r  <= req_nxt_s;
            cmd_r  <= cmd_nxt_s;
            opnd_r <= opnd_nxt_s;
        end
    end

    assign fma_req     = req_r;
    assign fma_command = cmd_r;
    assign fma_x       = opq_lane(opnd_r, 2'd0);
    assign fma_y       = opq_lane(opnd_r, 2'd1);
    assign fma_z       = opq_lane(opnd_r, 2'd2);
    assign fma_w       = opq_lane(opnd_r, 2'd3);

endmodule

// File: rtl/fmab_seq.sv
// Job sequencer for one fmab instance: optional clear, operand streaming,
// pipeline drain and result hand-off.
module fmab_seq
    import fmab_pkg::*;
#(
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = 3
)
(
    input  logic              clk,
    input  logic              reset,
    fmab_seq_if.slave         bus,
    output logic              fma_req,
    output logic [31:0]       fma_command,
    output logic [31:0]       fma_x,
    output logic [31:0]       fma_y,
    output logic [31:0]       fma_z,
    output logic [31:0]       fma_w,
    input  logic [127:0]      fma_acc,
    input  logic [39:0]       fma_exp,
    output logic              busy,
    output logic [LEN_W-1:0]  elem_cnt
);

    localparam int DRN_W = $clog2(PIPE_LAT + 1);

    seq_state_t         state_r;
    seq_state_t         state_nxt_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   elem_cnt_r;
    logic [DRN_W-1:0]   drain_cnt_r;
    logic               res_valid_r;
    logic [127:0]       res_acc_r;
    logic [39:0]        res_exp_r;
    logic               cmd_fire_s;
    logic               op_ready_s;
    logic               op_fire_s;
    logic               last_fire_s;
    logic               drain_load_s;
    logic               capture_s;

    assign cmd_fire_s   = (state_r == IDLE) && bus.cmd_valid;
    assign op_ready_s   = (state_r == RUN) && (elem_cnt_r < len_r);
    assign op_fire_s    = op_ready_s && bus.op_valid;
    // Widened by one bit so len = 2^LEN_W-1 compares without wrap
    assign last_fire_s  = op_fire_s &&
                          (({1'b0, elem_cnt_r} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_r});
    assign drain_load_s = (state_nxt_s == DRAIN) && (state_r != DRAIN);
    assign capture_s    = (state_r == DRAIN) && (drain_cnt_r == {DRN_W{1'b0}});

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_clear) begin
                        state_nxt_s = CLEAR;
                    end else if (bus.cmd_len != {LEN_W{1'b0}}) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                if (len_r != {LEN_W{1'b0}}) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            RUN: begin
                if (last_fire_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == {DRN_W{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Job length, element count and drain counter
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r       <= {LEN_W{1'b0}};
            elem_cnt_r  <= {LEN_W{1'b0}};
            drain_cnt_r <= {DRN_W{1'b0}};
        end else begin
            if (cmd_fire_s) begin
                len_r      <= bus.cmd_len;
                elem_cnt_r <= {LEN_W{1'b0}};
            end else if (op_fire_s) begin
                elem_cnt_r <= elem_cnt_r + LEN_W'(1);
            end else begin
                elem_cnt_r <= elem_cnt_r;
            end
            if (drain_load_s) begin
                drain_cnt_r <= DRN_W'(PIPE_LAT);
            end else if ((state_r == DRAIN) && (drain_cnt_r != {DRN_W{1'b0}})) begin
                drain_cnt_r <= drain_cnt_r - DRN_W'(1);
            end else begin
                drain_cnt_r <= drain_cnt_r;
            end
        end
    end

    // Result capture and hand-off
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_r <= 1'b0;
            res_acc_r   <= 128'd0;
            res_exp_r   <= 40'd0;
        end else if (capture_s) begin
            res_valid_r <= 1'b1;
            res_acc_r   <= fma_acc;
            res_exp_r   <= fma_exp;
        end else if ((state_r == DONE) && bus.res_ready) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    fmab_seq_issue u_issue (
        .clk         (clk),
        .reset       (reset),
        .state       (state_r),
        .cmd_fire    (cmd_fire_s),
        .cmd_clear   (bus.cmd_clear),
        .op_fire     (op_fire_s),
        .op_data     (bus.op_data),
        .fma_req     (fma_req),
        .fma_command (fma_command),
        .fma_x       (fma_x),
        .fma_y       (fma_y),
        .fma_z       (fma_z),
        .fma_w       (fma_w)
    );

    assign bus.cmd_ready = (state_r == IDLE);
    assign bus.op_ready  = op_ready_s;
    assign bus.res_valid = res_valid_r;
    assign bus.res_acc   = res_acc_r;
    assign bus.res_exp   = res_exp_r;
    assign busy          = (state_r != IDLE);
    assign elem_cnt      = elem_cnt_r;

endmodule

// File: tb/tb_fmab_seq.sv
// Directed bench for fmab_seq with a simple 3-stage stand-in for the fmab datapath
// (MAC adds each operand word into its lane, exp counts MACs per lane).
module tb_fmab_seq;
    import fmab_pkg::*;

    logic         clk;
    logic         reset;
    logic         fma_req;
    logic [31:0]  fma_command;
    logic [31:0]  fma_x, fma_y, fma_z, fma_w;
    logic [127:0] fma_acc;
    logic [39:0]  fma_exp;
    logic         busy;
    logic [15:0]  elem_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int clr_cnt = 0;
    int clr_before;

    fmab_seq_if #(.LEN_W(16)) bus ();

    fmab_seq #(.LEN_W(16), .PIPE_LAT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fma_req     (fma_req),
        .fma_command (fma_command),
        .fma_x       (fma_x),
        .fma_y       (fma_y),
        .fma_z       (fma_z),
        .fma_w       (fma_w),
        .fma_acc     (fma_acc),
        .fma_exp     (fma_exp),
        .busy        (busy),
        .elem_cnt    (elem_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: a request is reflected in acc/exp three cycles later
    logic         s1_req, s2_req;
    logic [31:0]  s1_cmd, s2_cmd;
    logic [127:0] s1_d, s2_d;
    logic [31:0]  a0, a1, a2, a3;
    logic [9:0]   e0, e1, e2, e3;

    always @(posedge clk) begin
        if (reset) begin
            s1_req <= 1'b0; s2_req <= 1'b0;
            s1_cmd <= 32'd0; s2_cmd <= 32'd0;
            s1_d <= 128'd0; s2_d <= 128'd0;
            a0 <= 32'd0; a1 <= 32'd0; a2 <= 32'd0; a3 <= 32'd0;
            e0 <= 10'd0; e1 <= 10'd0; e2 <= 10'd0; e3 <= 10'd0;
        end else begin
            s1_req <= fma_req; s1_cmd <= fma_command; s1_d <= {fma_x, fma_y, fma_z, fma_w};
            s2_req <= s1_req;  s2_cmd <= s1_cmd;      s2_d <= s1_d;
            if (s2_req && s2_cmd == 32'd2) begin
                a0 <= 32'd0; a1 <= 32'd0; a2 <= 32'd0; a3 <= 32'd0;
                e0 <= 10'd0; e1 <= 10'd0; e2 <= 10'd0; e3 <= 10'd0;
            end else if (s2_req && s2_cmd == 32'd1) begin
                a0 <= a0 + s2_d[127:96]; a1 <= a1 + s2_d[95:64];
                a2 <= a2 + s2_d[63:32];  a3 <= a3 + s2_d[31:0];
                e0 <= e0 + 10'd1; e1 <= e1 + 10'd1; e2 <= e2 + 10'd1; e3 <= e3 + 10'd1;
            end
        end
    end
    assign fma_acc = {a0, a1, a2, a3};
    assign fma_exp = {e0, e1, e2, e3};

    always @(negedge clk) begin
        if (fma_req === 1'b1 && fma_command === 32'd2) clr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams len copies of data back-to-back, then waits for and consumes the result
    task automatic run_job(input string tag, input logic [15:0] len, input logic [127:0] data,
                           input logic [127:0] exp_acc, input logic [39:0] exp_exp);
        int hs;
        int budget;
        chk({tag, "_cmd_ready"}, 128'(bus.cmd_ready), 128'(1'b1));
        bus.cmd_valid = 1'b1; bus.cmd_len = len; bus.cmd_clear = 1'b0;
        bus.op_valid = 1'b0; bus.op_data = data;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.op_valid = 1'b1;
        hs = 0; budget = 0;
        while (hs < int'(len) && budget < 50) begin
            if (bus.op_ready) hs++;
            @(negedge clk);
            budget++;
        end
        bus.op_valid = 1'b0;
        chk({tag, "_handshakes"}, 128'(hs), 128'(len));
        budget = 0;
        while (!bus.res_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_res_valid"}, 128'(bus.res_valid), 128'(1'b1));
        chk({tag, "_res_acc"}, bus.res_acc, exp_acc);
        chk({tag, "_res_exp"}, 128'(bus.res_exp), 128'(exp_exp));
        chk({tag, "_elem_cnt"}, 128'(elem_cnt), 128'(len));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_len = 16'd0; bus.cmd_clear = 1'b0;
        bus.op_valid = 1'b0; bus.op_data = 128'd0; bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fma_req", 128'(fma_req), 128'(1'b0));
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1'b1));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_res_valid", 128'(bus.res_valid), 128'(1'b0));
        chk("rst_elem_cnt", 128'(elem_cnt), 128'(16'd0));
        chk("rst_fma_command", 128'(fma_command), 128'(32'd0));
        chk("rst_op_ready", 128'(bus.op_ready), 128'(1'b0));
        chk("rst_fma_x", 128'(fma_x), 128'(32'd0));

        // Job 1: clear then four back-to-back quads
        bus.cmd_valid = 1'b1; bus.cmd_len = 16'd4; bus.cmd_clear = 1'b1;
        bus.op_valid = 1'b1; bus.op_data = {4{32'h3F803F80}};
        @(negedge clk);
        chk("t1_clr_req", 128'(fma_req), 128'(1'b1));
        chk("t1_clr_cmd", 128'(fma_command), 128'(32'd2));
        chk("t1_clr_opnd", 128'(fma_x), 128'(32'd0));
        chk("t1_busy_cmd_ready", 128'({busy, bus.cmd_ready}), 128'(2'b10));
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t1_gap_req", 128'(fma_req), 128'(1'b0));
        chk("t1_gap_cmd_nop", 128'(fma_command), 128'(32'd0));
        chk("t1_op_ready", 128'(bus.op_ready), 128'(1'b1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_mac_req", 128'(fma_req), 128'(1'b1));
            chk("t1_mac_cmd", 128'(fma_command), 128'(32'd1));
            chk("t1_mac_y", 128'(fma_y), 128'(32'h3F803F80));
        end
        chk("t1_op_ready_low", 128'(bus.op_ready), 128'(1'b0));
        chk("t1_elem_cnt", 128'(elem_cnt), 128'(16'd4));
        bus.op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_drain_res_valid", 128'(bus.res_valid), 128'(1'b0));
            chk("t1_drain_req", 128'(fma_req), 128'(1'b0));
        end
        @(negedge clk);
        chk("t1_res_valid", 128'(bus.res_valid), 128'(1'b1));
        chk("t1_res_acc", bus.res_acc, {4{32'hFE00FE00}});
        chk("t1_res_exp", 128'(bus.res_exp), 128'({4{10'd4}}));
        chk("t1_one_clear", 128'(clr_cnt), 128'(1));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("t1_consumed", 128'({bus.res_valid, bus.cmd_ready}), 128'(2'b01));

        // Job 2: len 3 with operand bubbles, no clear
        bus.cmd_valid = 1'b1; bus.cmd_len = 16'd3; bus.cmd_clear = 1'b0;
        bus.op_data = {32'd1, 32'd2, 32'd3, 32'd4};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("t2_no_clear_req", 128'(fma_req), 128'(1'b0));
        chk("t2_op_ready", 128'(bus.op_ready), 128'(1'b1));
        for (int i = 0; i < 5; i++) begin
            bus.op_valid = (i % 2 == 0);
            @(negedge clk);
            chk("t2_req_pattern", 128'(fma_req), 128'(i % 2 == 0));
        end
        chk("t2_op_ready_low", 128'(bus.op_ready), 128'(1'b0));
        chk("t2_elem_cnt", 128'(elem_cnt), 128'(16'd3));
        @(negedge clk);
        chk("t2_no_fourth_req", 128'(fma_req), 128'(1'b0));
        bus.op_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_drain_res_valid", 128'(bus.res_valid), 128'(1'b0));
        @(negedge clk);
        chk("t2_res_valid", 128'(bus.res_valid), 128'(1'b1));
        chk("t2_res_acc", bus.res_acc, {32'hFE00FE03, 32'hFE00FE06, 32'hFE00FE09, 32'hFE00FE0C});
        chk("t2_res_exp", 128'(bus.res_exp), 128'({4{10'd7}}));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;

        // Job 3: zero-length job, no clear
        bus.cmd_valid = 1'b1; bus.cmd_len = 16'd0; bus.cmd_clear = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("t3_busy", 128'(busy), 128'(1'b1));
        for (int i = 0; i < 4; i++) begin
            chk("t3_no_req", 128'(fma_req), 128'(1'b0));
            chk("t3_res_pending", 128'(bus.res_valid), 128'(1'b0));
            @(negedge clk);
        end
        chk("t3_res_valid", 128'(bus.res_valid), 128'(1'b1));
        chk("t3_res_acc", bus.res_acc, {32'hFE00FE03, 32'hFE00FE06, 32'hFE00FE09, 32'hFE00FE0C});
        chk("t3_elem_cnt", 128'(elem_cnt), 128'(16'd0));

        // Job 3 result held 10 cycles while a new command is offered
        bus.cmd_valid = 1'b1; bus.cmd_len = 16'd1; bus.cmd_clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 128'(bus.res_valid), 128'(1'b1));
            chk("t4_hold_acc", bus.res_acc, {32'hFE00FE03, 32'hFE00FE06, 32'hFE00FE09, 32'hFE00FE0C});
            chk("t4_hold_exp", 128'(bus.res_exp), 128'({4{10'd7}}));
            chk("t4_cmd_ready", 128'(bus.cmd_ready), 128'(1'b0));
            chk("t4_no_req", 128'(fma_req), 128'(1'b0));
        end
        bus.cmd_valid = 1'b0; bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("t4_idle", 128'({bus.res_valid, bus.cmd_ready, busy}), 128'(3'b010));
        chk("t4_cmd_ignored", 128'(clr_cnt), 128'(1));

        // Job 5: reset after 2 of 5 quads
        bus.cmd_valid = 1'b1; bus.cmd_len = 16'd5; bus.cmd_clear = 1'b0;
        bus.op_data = {4{32'h55}};
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.op_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_elem_cnt_mid", 128'(elem_cnt), 128'(16'd2));
        reset = 1'b1; bus.op_valid = 1'b0;
        @(negedge clk);
        chk("t5_req_after_rst", 128'(fma_req), 128'(1'b0));
        chk("t5_busy_after_rst", 128'(busy), 128'(1'b0));
        chk("t5_res_valid_after_rst", 128'(bus.res_valid), 128'(1'b0));
        chk("t5_elem_after_rst", 128'(elem_cnt), 128'(16'd0));
        chk("t5_cmd_ready_after_rst", 128'(bus.cmd_ready), 128'(1'b1));
        reset = 1'b0;

        // Jobs 6a/6b: accumulation carries across jobs without clear
        clr_before = clr_cnt;
        run_job("t6a", 16'd2, {32'h100, 32'h200, 32'h300, 32'h400},
                {32'h200, 32'h400, 32'h600, 32'h800}, {4{10'd2}});
        run_job("t6b", 16'd2, {32'h11, 32'h22, 32'h33, 32'h44},
                {32'h222, 32'h444, 32'h666, 32'h888}, {4{10'd4}});
        chk("t6_no_clear_cmd", 128'(clr_cnt), 128'(clr_before));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fmab_seq.md
Name: fmab_seq

Overview:
- Command-driven sequencer for the 4-lane bfloat16 multiply-accumulate datapath (fmab).
- Accepts a job (element count, optional accumulator clear) on a valid/ready command port.
- Streams operand quads from a valid/ready operand port into the datapath's req/x/y/z/w inputs, waits for the pipeline to drain, then presents the four accumulators and exponents on a valid/ready result port.
- Sits between the tile/DMA front-end and one fmab instance; it owns fmab's req and req_command.

Parameters:
- LEN_W, 16, width of the job element count.
- PIPE_LAT, 3, cycles from a registered fma_req until fmab acc/exp reflect that element.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  sequencer can accept a job
- cmd_len  in  LEN_W  number of operand quads in the job (0 legal)
- cmd_clear  in  1  zero the accumulators before the job
- op_valid  in  1  operand quad available
- op_ready  out  1  operand quad consumed this cycle when op_valid is also high
- op_data  in  128  {x,y,z,w}; each 32-bit word is a pair of bf16 values to be multiplied
- fma_req  out  1  to fmab req
- fma_command  out  32  to fmab req_command (integer)
- fma_x, fma_y, fma_z, fma_w  out  32 each  to fmab x/y/z/w
- fma_acc  in  128  {acc0,acc1,acc2,acc3} from fmab
- fma_exp  in  40  {exp0,exp1,exp2,exp3} from fmab
- res_valid  out  1  result held
- res_ready  in  1  result consumer handshake
- res_acc  out  128  captured accumulators
- res_exp  out  40  captured exponents
- busy  out  1  high in every state except IDLE
- elem_cnt  out  LEN_W  quads issued in the current job

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1. fma_req=0, res_valid=0, elem_cnt=0. A reset during any state aborts the job. fma_req is 0 in the cycle after reset is sampled. Any partially drained datapath result is discarded.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch len and clear, then:
  - go to CLEAR if cmd_clear=1;
  - otherwise go to RUN if len>0;
  - otherwise go to DRAIN.
- CLEAR: one cycle with a registered fma_req=1, fma_command=CMD_CLR and all operands 0. Next state is RUN if len>0, else DRAIN.
- RUN:
  - op_ready=1 while remaining>0.
  - Each op_valid&&op_ready handshake registers fma_req=1, fma_command=CMD_MAC and fma_x..w=op_data slices in the following cycle.
  - fma_req=0 in cycles without a handshake. Operand bubbles are legal.
  - elem_cnt increments per handshake.
  - When the handshake that makes elem_cnt==len occurs, op_ready drops in the same cycle and the FSM goes to DRAIN. op_ready is combinational from state and count, not from op_valid.
- DRAIN:
  - Down-counter loaded with PIPE_LAT on entry, counting from the cycle after the last registered fma_req.
  - fma_req=0 throughout.
  - When the counter reaches 0, register res_acc=fma_acc and res_exp=fma_exp, set res_valid=1 and go to DONE.
- DONE: hold res_* stable while res_valid=1. On res_ready, clear res_valid and go to IDLE; cmd_ready=1 in the following cycle. No new command is accepted while a result is unconsumed.
- fma_command idles at CMD_NOP whenever fma_req=0. fma_x..w hold their last value when fma_req=0.
- Accumulation persists across jobs when cmd_clear=0; the sequencer never clears implicitly.
- elem_cnt resets to 0 on command acceptance and saturates at len.
- Arithmetic: the count comparison is unsigned over LEN_W bits, so len=2^LEN_W-1 is legal. The DRAIN counter width is $clog2(PIPE_LAT+1).

Decomposition:
- Package fmab_pkg holds:
  - state enum seq_state_t {IDLE, CLEAR, RUN, DRAIN, DONE};
  - integer constants CMD_NOP=0, CMD_MAC=1, CMD_CLR=2;
  - localparam OPQ_W=128.
- One sub-module, fmab_seq_issue: the operand register stage that produces fma_req/command/x..w from handshake and state. The FSM and counters stay in fmab_seq.

Test Plan:
- Reset, then cmd_len=4, cmd_clear=1, four back-to-back quads of 0x3F803F80 -> one CMD_CLR req, then four CMD_MAC reqs on consecutive cycles, elem_cnt=4, res_valid exactly PIPE_LAT+1 cycles after the last req, res_acc equals fma_acc in that capture cycle.
- cmd_len=3 with op_valid toggling 1,0,1,0,1 -> fma_req pattern 1,0,1,0,1 delayed one cycle, op_ready low after the third handshake, and no fourth req.
- cmd_len=0, cmd_clear=0 -> no fma_req, res_valid after PIPE_LAT+1 cycles with the current accumulator values.
- res_ready held low for 10 cycles in DONE -> res_acc/res_exp stable, cmd_ready=0, and cmd_valid ignored; res_ready=1 -> IDLE next cycle.
- Reset asserted in the middle of RUN (after 2 of 5 quads) -> fma_req=0 and busy=0 in the next cycle, res_valid=0, and a new job starts cleanly.
- Two jobs without clear (len 2 then len 2) -> the second result reflects 4 accumulated quads against the bench model; fma_command is never CMD_CLR.
